// File: rtl/clk_ratio_meter_if.sv
// Result bundle of the clock ratio meter: measured clock in, period/duty/lock/stall out.
interface clk_ratio_meter_if #(
    parameter int CNT_W = 16
);
    logic             clk_in;
    logic [CNT_W-1:0] ratio;
    logic [CNT_W-1:0] high_time;
    logic             meas_valid;
    logic             locked;
    logic             stall;

    modport master (
        input  clk_in,
        output ratio, high_time, meas_valid, locked, stall
    );

    modport slave (
        output clk_in,
        input  ratio, high_time, meas_valid, locked, stall
    );
endinterface

// File: rtl/clk_ratio_meter.sv
// Measures the period of clk_in in clk cycles, with lock and stall detection.
// Optional duty measurement enabled by defining CLK_RATIO_METER_DUTY_EN.
module clk_ratio_meter #(
    parameter int          CNT_W    = 16,
    parameter int          LOCK_CNT = 4,
    parameter int unsigned TIMEOUT  = 32'hFFFF
) (
    input  logic            clk,
    input  logic            rst,
    clk_ratio_meter_if.master m
);
    localparam logic [CNT_W-1:0] TMO  = CNT_W'(TIMEOUT);
    localparam logic [3:0]       LOCK = 4'(LOCK_CNT);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, MEAS, STALL} state_t;

    state_t           state, state_nxt;
    logic             s1, s2, s3;
    logic             rise;
    logic [CNT_W-1:0] period_cnt;
    logic [CNT_W-1:0] ratio_q;
    logic [3:0]       match_cnt;
    logic [3:0]       match_nxt;
    logic             have_meas;
    logic             meas_valid_q;
    logic             locked_q;
    logic             stall_q;
    logic             start_evt;
    logic             meas_evt;
    logic             to_stall;

    assign rise = s2 & ~s3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (rise) state_nxt = MEAS;
            MEAS:    if (!rise && period_cnt == TMO) state_nxt = STALL;
            STALL:   if (rise) state_nxt = MEAS;
            default: state_nxt = IDLE;
        endcase
    end

    // A rise on the timeout cycle wins: it is a normal measurement.
    always_comb begin
        start_evt = rise && (state != MEAS);
        meas_evt  = rise && (state == MEAS);
        to_stall  = !rise && (state == MEAS) && (period_cnt == TMO);
        match_nxt = '0;
        if (have_meas && period_cnt == ratio_q)
            match_nxt = (match_cnt == LOCK) ? LOCK : match_cnt + 4'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1           <= 1'b0;
            s2           <= 1'b0;
            s3           <= 1'b0;
            period_cnt   <= '0;
            ratio_q      <= '0;
            match_cnt    <= '0;
            have_meas    <= 1'b0;
            meas_valid_q <= 1'b0;
            locked_q     <= 1'b0;
            stall_q      <= 1'b0;
        end else begin
            s1           <= m.clk_in;
            s2           <= s1;
            s3           <= s2;
            meas_valid_q <= 1'b0;
            if (start_evt) begin
                period_cnt <= ONE;
                stall_q    <= 1'b0;
                have_meas  <= 1'b0;
            end else if (meas_evt) begin
                ratio_q      <= period_cnt;
                meas_valid_q <= 1'b1;
                period_cnt   <= ONE;
                match_cnt    <= match_nxt;
                locked_q     <= (match_nxt == LOCK);
                have_meas    <= 1'b1;
            end else if (to_stall) begin
                stall_q   <= 1'b1;
                locked_q  <= 1'b0;
                match_cnt <= '0;
                ratio_q   <= '0;
            end else if (state == MEAS) begin
                period_cnt <= period_cnt + ONE;
            end
        end
    end

`ifdef CLK_RATIO_METER_DUTY_EN
    logic [CNT_W-1:0] high_cnt;
    logic [CNT_W-1:0] high_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            high_cnt <= '0;
            high_q   <= '0;
        end else if (start_evt) begin
            high_cnt <= ONE;
        end else if (meas_evt) begin
            high_q   <= high_cnt;
            high_cnt <= ONE;
        end else if (to_stall) begin
            high_q   <= '0;
        end else if (state == MEAS) begin
            high_cnt <= high_cnt + CNT_W'(s2);
        end
    end

    assign m.high_time = high_q;
`else
    assign m.high_time = '0;
`endif

    assign m.ratio      = ratio_q;
    assign m.meas_valid = meas_valid_q;
    assign m.locked     = locked_q;
    assign m.stall      = stall_q;
endmodule

// File: tb/tb_clk_ratio_meter.sv
// Scoreboard bench for clk_ratio_meter: directed divided clocks, timeout and reset.
module tb_clk_ratio_meter;
    localparam int W = 16;
`ifdef CLK_RATIO_METER_DUTY_EN
    localparam bit DUTY = 1'b1;
`else
    localparam bit DUTY = 1'b0;
`endif

    typedef struct {
        logic [W-1:0] ratio;
        logic [W-1:0] ht;
        logic         locked;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    int     cyc = 0;
    int     pass_cnt = 0;
    int     total_cnt = 0;
    int     last_rise = 0;
    exp_t   q[$];

    clk_ratio_meter_if #(.CNT_W(W)) bus ();

    clk_ratio_meter #(
        .CNT_W(W), .LOCK_CNT(4), .TIMEOUT(100)
    ) dut (
        .clk(clk), .rst(rst), .m(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [63:0] act, logic [63:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    task automatic push(int r, int h, bit l);
        exp_t e;
        e.ratio  = W'(r);
        e.ht     = DUTY ? W'(h) : '0;
        e.locked = l;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_div(int per, int hi, int n);
        for (int p = 0; p < n; p++) begin
            for (int c = 0; c < per; c++) begin
                bus.clk_in = (c < hi);
                if (c == 0) last_rise = cyc;
                tick();
            end
        end
    endtask

    task automatic chk_outs_zero(string tag);
        chk({tag, "_ratio"}, 64'(bus.ratio), 64'd0);
        chk({tag, "_high"}, 64'(bus.high_time), 64'd0);
        chk({tag, "_valid"}, 64'(bus.meas_valid), 64'd0);
        chk({tag, "_locked"}, 64'(bus.locked), 64'd0);
        chk({tag, "_stall"}, 64'(bus.stall), 64'd0);
    endtask

    // Monitor: every meas_valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && bus.meas_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_meas", {31'd0, bus.locked, bus.ratio, bus.high_time}, 64'hDEAD);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("meas", {31'd0, bus.locked, bus.ratio, bus.high_time},
                    {31'd0, e.locked, e.ratio, e.ht});
                chk("meas_no_stall", 64'(bus.stall), 64'd0);
            end
        end
    end

    initial begin
        int c0;
        bus.clk_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_outs_zero("reset");
        rst = 1'b0;
        tick();

        // divide-by-4 from reset, lock on 5th measurement
        for (int i = 1; i <= 5; i++) push(4, 2, i == 5);
        run_div(4, 2, 6);

        // switch to divide-by-6: lock drops then re-acquires
        push(4, 2, 1'b1);
        for (int i = 1; i <= 5; i++) push(6, 3, i == 5);
        run_div(6, 3, 6);

        // stop clk_in: stall 100 cycles after the last rise is detected
        c0 = last_rise;
        repeat (c0 + 102 - cyc) tick();
        chk("stall_early", 64'(bus.stall), 64'd0);
        tick();
        chk("stall_set", 64'(bus.stall), 64'd1);
        chk("stall_ratio", 64'(bus.ratio), 64'd0);
        chk("stall_locked", 64'(bus.locked), 64'd0);
        chk("stall_high", 64'(bus.high_time), 64'd0);

        // restart: first rise leaves stall, no measurement until next rise
        push(4, 2, 1'b0);
        push(4, 2, 1'b0);
        run_div(4, 2, 3);
        chk("stall_clear", 64'(bus.stall), 64'd0);

        // period equal to TIMEOUT: rise on the boundary is a measurement
        push(4, 2, 1'b0);
        push(100, 50, 1'b0);
        run_div(100, 50, 1);
        bus.clk_in = 1'b1;
        repeat (5) tick();
        chk("boundary_no_stall", 64'(bus.stall), 64'd0);
        repeat (45) tick();
        bus.clk_in = 1'b0;
        repeat (50) tick();

        // divide-by-5 with 3 high cycles
        push(100, 50, 1'b0);
        for (int i = 1; i <= 5; i++) push(5, 3, i == 5);
        run_div(5, 3, 6);
        chk("pre_rst_locked", 64'(bus.locked), 64'd1);

        // one-cycle reset mid-period
        rst = 1'b1;
        #1;
        chk_outs_zero("mid_rst");
        tick();
        rst = 1'b0;
        tick();
        push(4, 2, 1'b0);
        push(4, 2, 1'b0);
        run_div(4, 2, 3);

        repeat (10) tick();
        chk("queue_empty", 64'(q.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/clk_ratio_meter.md
Name: clk_ratio_meter

Overview:
Receive-side companion to the team's integer clock dividers. It measures an incoming divided clock (clk_in) against the reference clock clk and reports the integer period ratio. It also flags frequency lock, when consecutive periods match, and stall, when clk_in stops. Used for divider self-check and for clock-presence monitoring in bring-up logic.

Parameters:
CNT_W, 16, width of period/high-time counters and outputs
LOCK_CNT, 4, consecutive equal measurements (after the first) needed to assert locked; range 1-15
TIMEOUT, 16'hFFFF, clk cycles without a clk_in rising edge before stall; must be >= 2 and < 2**CNT_W

Ports:
clk  input  1  reference clock
rst  input  1  asynchronous, active-high reset
clk_in  input  1  measured clock, asynchronous to clk; frequency must be <= clk/2
ratio  output  CNT_W  last measured period, in clk cycles
high_time  output  CNT_W  clk cycles clk_in was sampled high in the last period
meas_valid  output  1  one-cycle pulse when ratio/high_time update
locked  output  1  ratio stable for LOCK_CNT further measurements
stall  output  1  no clk_in rising edge for TIMEOUT cycles

Behaviour:
- Reset: all outputs 0.
  - State IDLE; sync regs s1/s2/s3, period_cnt, high_cnt and match_cnt are all 0.
- Synchroniser: s1<=clk_in, s2<=s1, s3<=s2 on posedge clk.
  - rise = s2 & ~s3.
  - Edge-to-rise latency is 2-3 clk cycles, constant per edge, so it cancels in the ratio.
- FSM states: IDLE, MEAS, STALL.
- IDLE:
  - On rise: period_cnt<=1, high_cnt<=1, go MEAS.
  - No meas_valid, because the first partial period is discarded.
- MEAS, no rise:
  - period_cnt<=period_cnt+1.
  - high_cnt<=high_cnt+s2.
- MEAS, on rise:
  - ratio<=period_cnt, high_time<=high_cnt, meas_valid<=1 for exactly one cycle.
  - period_cnt<=1, high_cnt<=1.
- Sync-generated clk_in with period R gives ratio=R exactly.
- Lock logic, evaluated on each measurement:
  - If new period_cnt == current ratio and a previous valid measurement exists: match_cnt increments, saturating at LOCK_CNT.
  - Otherwise match_cnt<=0.
  - locked is registered and updates in the same cycle as meas_valid; it is 1 iff the new match_cnt == LOCK_CNT.
  - The first measurement after IDLE/STALL always gives match_cnt=0.
- Timeout:
  - In MEAS, if period_cnt == TIMEOUT and there is no rise this cycle: go STALL.
  - On entry to STALL: stall<=1, locked<=0, match_cnt<=0, ratio<=0, high_time<=0.
  - A rise in the same cycle as period_cnt==TIMEOUT takes priority: it is a normal measurement with ratio=TIMEOUT.
- STALL: on rise, stall<=0, period_cnt<=1, high_cnt<=1, go MEAS. The next measurement is the first valid one.
- Counters never wrap: TIMEOUT < 2**CNT_W bounds period_cnt.
- clk_in faster than clk/2 aliases; results are undefined, no detection.
- rst asserted mid-period: immediate return to reset values. The partial period is never reported.

Optional Feature:
CLK_RATIO_METER_DUTY_EN
- Defined: high_cnt logic present; high_time reports sampled high cycles as above.
- Undefined: high_cnt is removed; high_time is tied to 0; all other behaviour is identical.

Test Plan:
1. clk_in = sync divide-by-4 (2 high, 2 low) from reset: first meas_valid after the second rise; ratio=4; high_time=2 (DUTY_EN); locked=1 on the 5th meas_valid (LOCK_CNT=4).
2. Locked at ratio 4, switch to divide-by-6: first ratio=6 meas_valid drops locked in the same cycle; locked re-asserts on the 5th ratio=6 pulse.
3. TIMEOUT=100, stop clk_in low after a rise: stall=1 and ratio=0 exactly 100 cycles after rise; restart divide-by-4: stall=0 at first rise, first meas_valid one period later.
4. Divide-by-5 sync, high 3 cycles: ratio=5, high_time=3. Rebuild without DUTY_EN: high_time=0, ratio=5.
5. Assert rst for 1 cycle mid-period while locked: all outputs 0 immediately; no meas_valid until two rises after release.
6. Rise exactly when period_cnt==TIMEOUT (period=TIMEOUT): meas_valid with ratio=TIMEOUT, stall stays 0.
